// File: rtl/irq_claim_ctrl.sv
// irq_claim_ctrl: CPU-side claim/complete controller for the 8-source PLIC.
// Turns the priority determiner's winning request into one outstanding CPU
// interrupt with ack/EOI handshake, tracks the in-service source and returns
// a one-cycle clear pulse to that source's pending logic.
module irq_claim_ctrl #(
    parameter int unsigned ACK_TIMEOUT = 255
) (
    input  logic       pclk,
    input  logic       preset_n,
    input  logic       intr_ev,
    input  logic [3:0] vecto_no,
    output logic       cpu_irq,
    output logic [3:0] cpu_vec,
    input  logic       cpu_ack,
    input  logic       cpu_eoi,
    input  logic [3:0] eoi_vec,
    output logic [7:0] irq_clr,
    output logic [7:0] in_service,
    output logic       ack_timeout,
    output logic       eoi_err
);

    localparam int unsigned CNT_W = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ACK_TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        QUAL = 2'd1,
        REQ  = 2'd2,
        SERV = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [3:0]       cap_q, cap_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             cpu_irq_q, cpu_irq_d;
    logic [3:0]       cpu_vec_q, cpu_vec_d;
    logic [7:0]       irq_clr_q, irq_clr_d;
    logic [7:0]       in_service_q, in_service_d;
    logic             ack_timeout_q, ack_timeout_d;
    logic             eoi_err_q, eoi_err_d;

    // Vectors 1..8 name IRQ0..IRQ7; everything else is not a real source.
    function automatic logic vec_valid(input logic [3:0] v);
        return (v >= 4'd1) && (v <= 4'd8);
    endfunction

    // One-hot source mask for a valid vector (bit v-1).
    function automatic logic [7:0] vec_onehot(input logic [3:0] v);
        logic [2:0] idx;
        idx = 3'(v - 4'd1);
        return 8'h01 << idx;
    endfunction

    // State, capture, counter and registered outputs.
    always_ff @(posedge pclk or negedge preset_n) begin
        if (!preset_n) begin
            state_q       <= IDLE;
            cap_q         <= '0;
            cnt_q         <= '0;
            cpu_irq_q     <= 1'b0;
            cpu_vec_q     <= '0;
            irq_clr_q     <= '0;
            in_service_q  <= '0;
            ack_timeout_q <= 1'b0;
            eoi_err_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            cap_q         <= cap_d;
            cnt_q         <= cnt_d;
            cpu_irq_q     <= cpu_irq_d;
            cpu_vec_q     <= cpu_vec_d;
            irq_clr_q     <= irq_clr_d;
            in_service_q  <= in_service_d;
            ack_timeout_q <= ack_timeout_d;
            eoi_err_q     <= eoi_err_d;
        end
    end

    // Next-state and next-output logic; outputs follow the next state so the
    // CPU sees them in the same cycle the FSM occupies the new state.
    always_comb begin
        state_d       = state_q;
        cap_d         = cap_q;
        cnt_d         = cnt_q;
        irq_clr_d     = '0;
        ack_timeout_d = 1'b0;
        eoi_err_d     = 1'b0;

        case (state_q)
            IDLE: begin
                if (intr_ev && vec_valid(vecto_no)) begin
                    cap_d   = vecto_no;
                    state_d = QUAL;
                end
            end
            QUAL: begin
                // The determiner holds a changed vector one cycle; only a
                // repeated vector is believed.
                if (intr_ev && (vecto_no == cap_q)) begin
                    state_d = REQ;
                    cnt_d   = '0;
                end else if (intr_ev && vec_valid(vecto_no)) begin
                    cap_d = vecto_no;
                end else begin
                    state_d = IDLE;
                    cap_d   = '0;
                end
            end
            REQ: begin
                // Ack on the terminal count still wins over the timeout.
                if (cpu_ack) begin
                    state_d   = SERV;
                    irq_clr_d = vec_onehot(cap_q);
                end else if (cnt_q == CNT_LAST) begin
                    state_d       = IDLE;
                    cap_d         = '0;
                    ack_timeout_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            SERV: begin
                if (cpu_eoi) begin
                    if (eoi_vec == cap_q) begin
                        state_d = IDLE;
                        cap_d   = '0;
                    end else begin
                        eoi_err_d = 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                cap_d   = '0;
            end
        endcase

        // Nothing is in service outside SERV, so any EOI there is spurious.
        if (cpu_eoi && (state_q != SERV)) begin
            eoi_err_d = 1'b1;
        end

        cpu_irq_d    = (state_d == REQ);
        cpu_vec_d    = ((state_d == REQ) || (state_d == SERV)) ? cap_d : 4'd0;
        in_service_d = (state_d == SERV) ? vec_onehot(cap_d) : 8'h00;
    end

    assign cpu_irq     = cpu_irq_q;
    assign cpu_vec     = cpu_vec_q;
    assign irq_clr     = irq_clr_q;
    assign in_service  = in_service_q;
    assign ack_timeout = ack_timeout_q;
    assign eoi_err     = eoi_err_q;

endmodule

// File: tb/tb_irq_claim_ctrl.sv
// Directed, table-driven bench for irq_claim_ctrl with a short ack timeout.
module tb_irq_claim_ctrl;

    logic       pclk;
    logic       preset_n;
    logic       intr_ev;
    logic [3:0] vecto_no;
    logic       cpu_irq;
    logic [3:0] cpu_vec;
    logic       cpu_ack;
    logic       cpu_eoi;
    logic [3:0] eoi_vec;
    logic [7:0] irq_clr;
    logic [7:0] in_service;
    logic       ack_timeout;
    logic       eoi_err;

    int n_checks;
    int n_fail;

    irq_claim_ctrl #(.ACK_TIMEOUT(4)) dut (
        .pclk        (pclk),
        .preset_n    (preset_n),
        .intr_ev     (intr_ev),
        .vecto_no    (vecto_no),
        .cpu_irq     (cpu_irq),
        .cpu_vec     (cpu_vec),
        .cpu_ack     (cpu_ack),
        .cpu_eoi     (cpu_eoi),
        .eoi_vec     (eoi_vec),
        .irq_clr     (irq_clr),
        .in_service  (in_service),
        .ack_timeout (ack_timeout),
        .eoi_err     (eoi_err)
    );

    initial pclk = 1'b0;
    always #5 pclk = ~pclk;

    typedef struct {
        logic       ev;
        logic [3:0] vno;
        logic       ack;
        logic       eoi;
        logic [3:0] evec;
        logic       x_irq;
        logic [3:0] x_vec;
        logic [7:0] x_clr;
        logic [7:0] x_is;
        logic       x_to;
        logic       x_err;
    } vec_t;

    vec_t tbl[$];

    task automatic row(input logic ev, input logic [3:0] vno, input logic ack,
                       input logic eoi, input logic [3:0] evec,
                       input logic x_irq, input logic [3:0] x_vec,
                       input logic [7:0] x_clr, input logic [7:0] x_is,
                       input logic x_to, input logic x_err);
        vec_t r;
        r.ev = ev; r.vno = vno; r.ack = ack; r.eoi = eoi; r.evec = evec;
        r.x_irq = x_irq; r.x_vec = x_vec; r.x_clr = x_clr; r.x_is = x_is;
        r.x_to = x_to; r.x_err = x_err;
        tbl.push_back(r);
    endtask

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic x_irq, input logic [3:0] x_vec,
                           input logic [7:0] x_clr, input logic [7:0] x_is,
                           input logic x_to, input logic x_err);
        chk({tag, ".cpu_irq"},     8'(cpu_irq),     8'(x_irq));
        chk({tag, ".cpu_vec"},     8'(cpu_vec),     8'(x_vec));
        chk({tag, ".irq_clr"},     irq_clr,         x_clr);
        chk({tag, ".in_service"},  in_service,      x_is);
        chk({tag, ".ack_timeout"}, 8'(ack_timeout), 8'(x_to));
        chk({tag, ".eoi_err"},     8'(eoi_err),     8'(x_err));
    endtask

    task automatic drive(input logic ev, input logic [3:0] vno, input logic ack,
                         input logic eoi, input logic [3:0] evec);
        intr_ev = ev; vecto_no = vno; cpu_ack = ack; cpu_eoi = eoi; eoi_vec = evec;
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        preset_n = 1'b0;
        drive(1'b0, 4'd0, 1'b0, 1'b0, 4'd0);

        //   ev vno ack eoi evec | irq vec clr    is     to err
        // Basic claim of vector 3
        row(1, 3, 0, 0, 0,   0, 0, 8'h00, 8'h00, 0, 0);
        row(1, 3, 0, 0, 0,   1, 3, 8'h00, 8'h00, 0, 0);
        row(1, 3, 1, 0, 0,   0, 3, 8'h04, 8'h04, 0, 0);
        row(0, 0, 0, 0, 0,   0, 3, 8'h00, 8'h04, 0, 0);
        row(0, 0, 0, 1, 3,   0, 0, 8'h00, 8'h00, 0, 0);
        // Vector change 5 -> 7 during qualification
        row(1, 5, 0, 0, 0,   0, 0, 8'h00, 8'h00, 0, 0);
        row(1, 7, 0, 0, 0,   0, 0, 8'h00, 8'h00, 0, 0);
        row(1, 7, 0, 0, 0,   1, 7, 8'h00, 8'h00, 0, 0);
        row(0, 0, 1, 0, 0,   0, 7, 8'h40, 8'h40, 0, 0);
        row(0, 0, 0, 1, 7,   0, 0, 8'h00, 8'h00, 0, 0);
        // Unclaimed vector 4: four cycles high, timeout, re-raise
        row(1, 4, 0, 0, 0,   0, 0, 8'h00, 8'h00, 0, 0);
        row(1, 4, 0, 0, 0,   1, 4, 8'h00, 8'h00, 0, 0);
        row(1, 4, 0, 0, 0,   1, 4, 8'h00, 8'h00, 0, 0);
        row(1, 4, 0, 0, 0,   1, 4, 8'h00, 8'h00, 0, 0);
        row(1, 4, 0, 0, 0,   1, 4, 8'h00, 8'h00, 0, 0);
        row(1, 4, 0, 0, 0,   0, 0, 8'h00, 8'h00, 1, 0);
        row(1, 4, 0, 0, 0,   0, 0, 8'h00, 8'h00, 0, 0);
        row(1, 4, 0, 0, 0,   1, 4, 8'h00, 8'h00, 0, 0);
        // Ack on the terminal count beats the timeout
        row(1, 4, 0, 0, 0,   1, 4, 8'h00, 8'h00, 0, 0);
        row(1, 4, 0, 0, 0,   1, 4, 8'h00, 8'h00, 0, 0);
        row(1, 4, 0, 0, 0,   1, 4, 8'h00, 8'h00, 0, 0);
        row(1, 4, 1, 0, 0,   0, 4, 8'h08, 8'h08, 0, 0);
        row(0, 0, 0, 1, 4,   0, 0, 8'h00, 8'h00, 0, 0);
        // Vector 2 in service, wrong EOI, vector 8 held off
        row(1, 2, 0, 0, 0,   0, 0, 8'h00, 8'h00, 0, 0);
        row(1, 2, 0, 0, 0,   1, 2, 8'h00, 8'h00, 0, 0);
        row(1, 2, 1, 0, 0,   0, 2, 8'h02, 8'h02, 0, 0);
        row(1, 8, 0, 1, 6,   0, 2, 8'h00, 8'h02, 0, 1);
        row(1, 8, 0, 0, 0,   0, 2, 8'h00, 8'h02, 0, 0);
        row(1, 8, 1, 0, 0,   0, 2, 8'h00, 8'h02, 0, 0);
        row(1, 8, 0, 1, 2,   0, 0, 8'h00, 8'h00, 0, 0);
        row(1, 8, 0, 0, 0,   0, 0, 8'h00, 8'h00, 0, 0);
        row(1, 8, 0, 0, 0,   1, 8, 8'h00, 8'h00, 0, 0);
        row(0, 0, 1, 0, 0,   0, 8, 8'h80, 8'h80, 0, 0);
        row(0, 0, 0, 1, 8,   0, 0, 8'h00, 8'h00, 0, 0);
        // Invalid vectors and spurious EOI in IDLE
        row(1, 0, 0, 0, 0,   0, 0, 8'h00, 8'h00, 0, 0);
        row(1, 9, 0, 0, 0,   0, 0, 8'h00, 8'h00, 0, 0);
        row(1, 15, 0, 0, 0,  0, 0, 8'h00, 8'h00, 0, 0);
        row(0, 0, 0, 1, 1,   0, 0, 8'h00, 8'h00, 0, 1);
        // Request dropped during qualification, then claim vector 1
        row(1, 1, 0, 0, 0,   0, 0, 8'h00, 8'h00, 0, 0);
        row(0, 1, 0, 0, 0,   0, 0, 8'h00, 8'h00, 0, 0);
        row(1, 1, 0, 0, 0,   0, 0, 8'h00, 8'h00, 0, 0);
        row(1, 1, 0, 0, 0,   1, 1, 8'h00, 8'h00, 0, 0);
        row(1, 1, 0, 1, 5,   1, 1, 8'h00, 8'h00, 0, 1);

        repeat (2) @(posedge pclk);
        #1;
        chk_all("reset", 1'b0, 4'd0, 8'h00, 8'h00, 1'b0, 1'b0);
        @(negedge pclk);
        preset_n = 1'b1;

        for (int i = 0; i < tbl.size(); i++) begin
            @(negedge pclk);
            drive(tbl[i].ev, tbl[i].vno, tbl[i].ack, tbl[i].eoi, tbl[i].evec);
            @(posedge pclk);
            #1;
            chk_all($sformatf("row%0d", i), tbl[i].x_irq, tbl[i].x_vec, tbl[i].x_clr,
                    tbl[i].x_is, tbl[i].x_to, tbl[i].x_err);
        end

        // Reset mid-REQ clears outputs immediately, without a clock edge.
        @(negedge pclk);
        drive(1'b1, 4'd1, 1'b0, 1'b0, 4'd0);
        #2;
        preset_n = 1'b0;
        #1;
        chk_all("rst_mid_req", 1'b0, 4'd0, 8'h00, 8'h00, 1'b0, 1'b0);
        @(posedge pclk);
        #1;
        chk_all("rst_held", 1'b0, 4'd0, 8'h00, 8'h00, 1'b0, 1'b0);
        @(negedge pclk);
        preset_n = 1'b1;
        // Held request after reset needs a fresh qualification.
        @(posedge pclk);
        #1;
        chk_all("post_rst_qual", 1'b0, 4'd0, 8'h00, 8'h00, 1'b0, 1'b0);
        @(posedge pclk);
        #1;
        chk_all("post_rst_req", 1'b1, 4'd1, 8'h00, 8'h00, 1'b0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
